// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator and anything that models it.
// Mode selects the feedback topology of lfsr_gen and lfsr_step_comb.
package lfsr_pkg;

    localparam int unsigned MODE_FIBONACCI = 0;
    localparam int unsigned MODE_GALOIS    = 1;

endpackage

// File: rtl/lfsr_step_comb.sv
// One combinational LFSR shift, Fibonacci or Galois topology.
// bit_o is the bit shifted out of stage 0 by this step.
module lfsr_step_comb
    import lfsr_pkg::*;
#(
    parameter int unsigned       Width = 16,
    parameter logic [Width-1:0]  Taps  = 16'hB400,
    parameter int unsigned       Mode  = MODE_GALOIS
) (
    input  logic [Width-1:0] state_i,
    output logic [Width-1:0] state_o,
    output logic             bit_o
);

    assign bit_o = state_i[0];

    if (Mode == MODE_GALOIS) begin : g_galois
        assign state_o = (state_i >> 1) ^ (state_i[0] ? Taps : '0);
    end else begin : g_fib
        assign state_o = {^(state_i & Taps), state_i[Width-1:1]};
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with multi-step advance, seed load,
// zero-seed guard and period-wrap detection.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned       Width         = 16,
    parameter logic [Width-1:0]  Taps          = 16'hB400,
    parameter int unsigned       Mode          = MODE_GALOIS,
    parameter logic [Width-1:0]  Seed          = 16'hACE1,
    parameter int unsigned       StepsPerCycle = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     load_i,
    input  logic [Width-1:0]         seed_i,
    output logic [Width-1:0]         q_o,
    output logic [StepsPerCycle-1:0] rnd_o,
    output logic                     valid_o,
    output logic                     period_o,
    output logic                     seed_err_o
);

    if (Width < 3) begin : g_err_width
        $error("lfsr_gen: Width must be >= 3");
    end
    if (Seed == '0) begin : g_err_seed
        $error("lfsr_gen: Seed must be nonzero");
    end
    if (StepsPerCycle < 1 || StepsPerCycle > Width) begin : g_err_steps
        $error("lfsr_gen: StepsPerCycle must be in 1..Width");
    end
    if (Mode == MODE_GALOIS && !Taps[Width-1]) begin : g_err_gal
        $error("lfsr_gen: Galois taps need the top stage set");
    end
    if (Mode != MODE_GALOIS && !Taps[0]) begin : g_err_fib
        $error("lfsr_gen: Fibonacci taps need stage 0 set");
    end

    logic [Width-1:0]         state;
    logic [Width-1:0]         seed_q;
    logic [Width-1:0]         next_state;
    logic [Width-1:0]         load_val;
    logic                     seed_zero;
    logic [StepsPerCycle-1:0] step_bits;
    logic [StepsPerCycle-1:0] rnd;
    logic                     valid;
    logic                     period;
    logic                     err;
    logic [Width-1:0]         chain [0:StepsPerCycle];

    // Steps are chained so rnd bit k is the output of step k in this cycle.
    assign chain[0] = state;

    for (genvar i = 0; i < StepsPerCycle; i++) begin : g_step
        lfsr_step_comb #(
            .Width (Width),
            .Taps  (Taps),
            .Mode  (Mode)
        ) u_step (
            .state_i (chain[i]),
            .state_o (chain[i+1]),
            .bit_o   (step_bits[i])
        );
    end

    assign next_state = chain[StepsPerCycle];

    // A zero seed would lock the register; fall back to the reset seed.
    assign seed_zero = (seed_i == '0);
    assign load_val  = seed_zero ? Seed : seed_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= Seed;
            seed_q <= Seed;
            rnd    <= '0;
            valid  <= 1'b0;
            period <= 1'b0;
            err    <= 1'b0;
        end else if (load_i) begin
            state  <= load_val;
            seed_q <= load_val;
            err    <= seed_zero;
            valid  <= 1'b0;
            period <= 1'b0;
        end else if (en_i) begin
            state  <= next_state;
            rnd    <= step_bits;
            valid  <= 1'b1;
            period <= (next_state == seed_q);
        end else begin
            valid  <= 1'b0;
            period <= 1'b0;
        end
    end

    assign q_o        = state;
    assign rnd_o      = rnd;
    assign valid_o    = valid;
    assign period_o   = period;
    assign seed_err_o = err;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: four configurations against an arithmetic reference model.
// Directed spec sequences first, then randomized en/load/seed/reset traffic.
module tb_lfsr_gen;
    import lfsr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] seed = '0;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] q0, q1, q2;
    logic [3:0]  q3;
    logic        r0, r1, r3;
    logic [3:0]  r2;
    logic [3:0]  v, p, e;

    always #5 clk = ~clk;

    lfsr_gen u_gal (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .seed_i(seed),
        .q_o(q0), .rnd_o(r0), .valid_o(v[0]), .period_o(p[0]), .seed_err_o(e[0])
    );

    lfsr_gen #(.Taps(16'h002D), .Mode(MODE_FIBONACCI)) u_fib (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .seed_i(seed),
        .q_o(q1), .rnd_o(r1), .valid_o(v[1]), .period_o(p[1]), .seed_err_o(e[1])
    );

    lfsr_gen #(.StepsPerCycle(4)) u_gal4 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .seed_i(seed),
        .q_o(q2), .rnd_o(r2), .valid_o(v[2]), .period_o(p[2]), .seed_err_o(e[2])
    );

    lfsr_gen #(.Width(4), .Taps(4'hC), .Seed(4'h1)) u_w4 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .seed_i(seed[3:0]),
        .q_o(q3), .rnd_o(r3), .valid_o(v[3]), .period_o(p[3]), .seed_err_o(e[3])
    );

    logic [15:0] dq [4];
    logic [3:0]  dr [4];
    assign dq[0] = q0;
    assign dq[1] = q1;
    assign dq[2] = q2;
    assign dq[3] = {12'b0, q3};
    assign dr[0] = {3'b0, r0};
    assign dr[1] = {3'b0, r1};
    assign dr[2] = r2;
    assign dr[3] = {3'b0, r3};

    // Per-instance configuration
    int          pw [4] = '{16, 16, 16, 4};
    logic [15:0] pt [4] = '{16'hB400, 16'h002D, 16'hB400, 16'h000C};
    int          pm [4] = '{1, 0, 1, 1};
    logic [15:0] ps [4] = '{16'hACE1, 16'hACE1, 16'hACE1, 16'h0001};
    int          pn [4] = '{1, 1, 4, 1};

    // Reference model state
    logic [15:0] ms [4];
    logic [15:0] mq [4];
    logic [3:0]  mr [4];
    logic        mv [4];
    logic        mp [4];
    logic        me [4];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {out_bit, next_state} for one shift of a w-bit register.
    function automatic logic [16:0] ref_step(input logic [15:0] s, input int w,
                                             input logic [15:0] taps, input int mode);
        int          ones;
        logic [15:0] nxt;
        nxt = s / 2;
        if (mode == MODE_GALOIS) begin
            if (s % 2 == 1) nxt = nxt ^ taps;
        end else begin
            ones = 0;
            for (int i = 0; i < w; i++)
                if (s[i] && taps[i]) ones++;
            nxt = nxt + 16'((ones % 2) << (w - 1));
        end
        return {s[0], nxt};
    endfunction

    task automatic model_edge();
        logic [15:0] mask, ld, s;
        logic [16:0] st;
        for (int d = 0; d < 4; d++) begin
            mask = 16'((32'd1 << pw[d]) - 1);
            if (!rst_n) begin
                ms[d] = ps[d]; mq[d] = ps[d]; mr[d] = '0;
                mv[d] = 0; mp[d] = 0; me[d] = 0;
            end else if (load) begin
                ld = seed & mask;
                me[d] = (ld == 0);
                if (ld == 0) ld = ps[d];
                ms[d] = ld; mq[d] = ld;
                mv[d] = 0; mp[d] = 0;
            end else if (en) begin
                s = ms[d];
                mr[d] = '0;
                for (int k = 0; k < pn[d]; k++) begin
                    st = ref_step(s, pw[d], pt[d], pm[d]);
                    mr[d][k] = st[16];
                    s = st[15:0];
                end
                ms[d] = s;
                mv[d] = 1;
                mp[d] = (s == mq[d]);
            end else begin
                mv[d] = 0; mp[d] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("d%0d_q", d), 32'(dq[d]), 32'(ms[d]));
            check($sformatf("d%0d_rnd", d), 32'(dr[d]), 32'(mr[d]));
            check($sformatf("d%0d_valid", d), 32'(v[d]), 32'(mv[d]));
            check($sformatf("d%0d_period", d), 32'(p[d]), 32'(mp[d]));
            check($sformatf("d%0d_err", d), 32'(e[d]), 32'(me[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    bit seen [16];

    initial begin
        // Reset state
        rst_n = 0; en = 1; load = 0;
        tick(); tick();
        check("rst_q", 32'(q0), 32'h0000ACE1);
        check("rst_q_w4", 32'(q3), 32'h1);
        check("rst_valid", 32'(v), 32'h0);

        // Tests 1-4: continuous enable from reset
        rst_n = 1; en = 1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) begin
                check("t1_q1", 32'(q0), 32'h0000E270);
                check("t1_r1", 32'(r0), 32'h1);
                check("t1_v1", 32'(v[0]), 32'h1);
                check("t2_q1", 32'(q1), 32'h00005670);
                check("t2_r1", 32'(r1), 32'h1);
                check("t3_q", 32'(q2), 32'h00001C4E);
                check("t3_r", 32'(r2), 32'h1);
                check("t3_v", 32'(v[2]), 32'h1);
            end
            if (k == 2) begin
                check("t1_q2", 32'(q0), 32'h00007138);
                check("t1_r2", 32'(r0), 32'h0);
                check("t1_v2", 32'(v[0]), 32'h1);
                check("t2_q2", 32'(q1), 32'h0000AB38);
                check("t2_r2", 32'(r1), 32'h0);
            end
            check("t4_period", 32'(p[3]), 32'(k % 15 == 0));
            if (k <= 15) begin
                check("t4_nonzero", 32'(q3 != 0), 32'h1);
                check("t4_distinct", 32'(seen[q3]), 32'h0);
                seen[q3] = 1'b1;
            end
        end
        en = 0;
        tick();
        check("hold_valid", 32'(v[2]), 32'h0);

        // Test 5: zero-seed guard, load beats enable
        load = 1; seed = 16'h0000;
        tick();
        check("t5_q_zero", 32'(q0), 32'h0000ACE1);
        check("t5_err_set", 32'(e[0]), 32'h1);
        seed = 16'h1234; en = 1;
        tick();
        check("t5_q_load", 32'(q0), 32'h00001234);
        check("t5_err_clr", 32'(e[0]), 32'h0);
        check("t5_valid", 32'(v[0]), 32'h0);

        // Test 6: reset mid-run
        load = 0; en = 1;
        repeat (5) tick();
        rst_n = 0;
        tick();
        check("t6_q", 32'(q0), 32'h0000ACE1);
        check("t6_valid", 32'(v[0]), 32'h0);
        check("t6_rnd", 32'(r2), 32'h0);
        check("t6_period", 32'(p[0]), 32'h0);
        rst_n = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            en    = ($urandom_range(0, 3) != 0);
            load  = ($urandom_range(0, 15) == 0);
            seed  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
